// File: rtl/wb_sram_pkg.sv
// ---------------------------------------------------------------------------
// wb_sram_pkg
// Shared definitions for the SRAM Wishbone arbiter slice.
//   - Wishbone width constants (address, data, byte select).
//   - Arbiter state encoding, kept as plain logic [1:0] constants so older
//     code that compares raw state values keeps working.
//   - arb_grant(): maps an arbiter state onto the one-hot grant vector.
// ---------------------------------------------------------------------------
package wb_sram_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_OWN0 = 2'd1;
    localparam logic [1:0] ARB_OWN1 = 2'd2;

    // One-hot owner vector: bit 0 = master 0 owns, bit 1 = master 1 owns.
    function automatic logic [1:0] arb_grant(input logic [1:0] st);
        logic [1:0] g;
        g[0] = (st == ARB_OWN0);
        g[1] = (st == ARB_OWN1);
        return g;
    endfunction

endpackage : wb_sram_pkg

// File: rtl/wb_sram_arb_prio.sv
// ---------------------------------------------------------------------------
// wb_sram_arb_prio
// Combinational tie-break for the two-master SRAM arbiter. Only consulted
// while the arbiter is idle.
//
// Compile switch: WB_SRAM_ARB_RR_EN
//   defined   -> on a tie the master that did NOT own the bus last wins.
//   undefined -> fixed priority, master 0 always wins a tie; last_owner is
//                ignored.
//
// Ports
//   req        in  2  request vector {m1_cyc, m0_cyc}
//   last_owner in  1  index of the master that was granted most recently
//   winner     out 1  index of the master to grant (0 or 1)
// ---------------------------------------------------------------------------
module wb_sram_arb_prio
    import wb_sram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner
);

`ifdef WB_SRAM_ARB_RR_EN
    // Round-robin pick: a lone requester wins, a tie goes to the non-last owner.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_owner;
            default: winner = 1'b0;
        endcase
    end
`else
    // last_owner has no meaning under fixed priority.
    logic unused_last_owner_s;
    assign unused_last_owner_s = last_owner;

    // Fixed-priority pick: master 1 wins only when it requests alone.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = 1'b0;
            default: winner = 1'b0;
        endcase
    end
`endif

endmodule : wb_sram_arb_prio

// File: rtl/wb_sram_arb2.sv
// ---------------------------------------------------------------------------
// wb_sram_arb2
// Two-master Wishbone arbiter in front of the 32-bit slave port of the
// 16-bit SRAM controller. Master 0 is the CPU data port, master 1 a second
// master (instruction fetch, DMA, video). The owner keeps the bus for as
// long as it holds cyc, so locked multi-beat sequences are possible.
//
// Compile switch: WB_SRAM_ARB_RR_EN (round-robin on ties in IDLE; when
// undefined master 0 wins ties and the last-owner register does not exist).
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   m0_cyc_i/stb_i/we_i          master 0 Wishbone control
//   m0_adr_i[31:0], m0_sel_i[3:0], m0_dat_i[31:0]   master 0 request
//   m0_dat_o[31:0], m0_ack_o     master 0 response
//   m1_*                         master 1, same set as master 0
//   s_cyc_o/stb_o/we_o           to SRAM controller
//   s_adr_o[31:0], s_sel_o[3:0], s_dat_o[31:0]      to SRAM controller
//   s_dat_i[31:0], s_ack_i       from SRAM controller
//   grant[1:0]                   one-hot current owner, 2'b00 when idle
// ---------------------------------------------------------------------------
module wb_sram_arb2
    import wb_sram_pkg::*;
(
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    output logic                m0_ack_o,

    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                m1_ack_o,

    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    input  logic [WB_DAT_W-1:0] s_dat_i,
    input  logic                s_ack_i,

    output logic [1:0]          grant
);

    logic [1:0] state_r;
    logic [1:0] next_state_s;
    logic       winner_s;
    logic       prio_last_s;

    // Tie-break between simultaneous requests seen in IDLE.
    wb_sram_arb_prio u_prio (
        .req        ({m1_cyc_i, m0_cyc_i}),
        .last_owner (prio_last_s),
        .winner     (winner_s)
    );

`ifdef WB_SRAM_ARB_RR_EN
    logic last_owner_r;

    // Remember who entered an OWN state last; reset value 1 lets master 0
    // take the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_r <= 1'b1;
        end else if (next_state_s == ARB_OWN0) begin
            last_owner_r <= 1'b0;
        end else if (next_state_s == ARB_OWN1) begin
            last_owner_r <= 1'b1;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end

    assign prio_last_s = last_owner_r;
`else
    assign prio_last_s = 1'b1;
`endif

    // Grant state register; reset drops ownership immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic. On release the waiting master takes over directly;
    // the releasing master has cyc low on that edge, so it can never beat
    // the waiting one.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    next_state_s = winner_s ? ARB_OWN1 : ARB_OWN0;
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            ARB_OWN0: begin
                if (m0_cyc_i) begin
                    next_state_s = ARB_OWN0;
                end else if (m1_cyc_i) begin
                    next_state_s = ARB_OWN1;
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            ARB_OWN1: begin
                if (m1_cyc_i) begin
                    next_state_s = ARB_OWN1;
                end else if (m0_cyc_i) begin
                    next_state_s = ARB_OWN0;
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            default: next_state_s = ARB_IDLE;
        endcase
    end

    // Slave-side request mux: the owner's signals pass straight through,
    // everything is held at zero while idle.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = {WB_ADR_W{1'b0}};
        s_sel_o = {WB_SEL_W{1'b0}};
        s_dat_o = {WB_DAT_W{1'b0}};
        case (state_r)
            ARB_OWN0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_sel_o = m0_sel_i;
                s_dat_o = m0_dat_i;
            end
            ARB_OWN1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_sel_o = m1_sel_i;
                s_dat_o = m1_dat_i;
            end
            ARB_IDLE: begin
                s_cyc_o = 1'b0;
                s_stb_o = 1'b0;
            end
            default: begin
                s_cyc_o = 1'b0;
                s_stb_o = 1'b0;
            end
        endcase
    end

    // Grant comes from the registered state, so an ack arriving in the same
    // cycle the owner drops cyc is still routed to that owner.
    assign grant = arb_grant(state_r);

    assign m0_ack_o = s_ack_i & grant[0];
    assign m1_ack_o = s_ack_i & grant[1];

    // Read data is broadcast; only the acked master consumes it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule : wb_sram_arb2
